// File: rtl/controle_multdiv_pkg.sv
// Shared constants for the mult/div sequencer: Funct codes decoded by the
// ALU control and the state encoding of the sequencer FSM.
package pacote_multdiv;

    localparam logic [5:0] FUNCT_MULT = 6'b000010;
    localparam logic [5:0] FUNCT_DIV  = 6'b000011;

    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        MULT   = 2'b01,
        DIV    = 2'b10,
        FIM    = 2'b11
    } estado_t;

endpackage

// File: rtl/controle_multdiv_datapath.sv
// Iterative datapath for unsigned shift-add multiply and restoring divide.
// One shared pair of working registers holds either the product accumulator
// ({hi, lo}, lo initially holding the multiplier) or the partial remainder
// (hi) and the dividend/quotient shift register (lo). The result registers
// HI/LO/Div_Zero only change on a completion or on a divide-by-zero accept.
module multdiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             div_sel_i,
    input  logic             step_mult_i,
    input  logic             step_div_i,
    input  logic             last_i,
    input  logic             dz_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dz_q;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   part_s;
    logic [WIDTH+1:0] diff_s;
    logic [WIDTH-1:0] nxt_hi_s;
    logic [WIDTH-1:0] nxt_lo_s;

    // One iteration of either algorithm, selected by the active step enable.
    always_comb begin
        nxt_hi_s = acc_hi_q;
        nxt_lo_s = acc_lo_q;
        // Multiply: add multiplicand when the current multiplier bit is set,
        // then shift the whole {carry, hi, lo} right by one.
        if (acc_lo_q[0]) begin
            sum_s = {1'b0, acc_hi_q} + {1'b0, opnd_q};
        end else begin
            sum_s = {1'b0, acc_hi_q};
        end
        // Divide: bring in the next dividend bit and trial-subtract the divisor.
        part_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
        diff_s = {1'b0, part_s} - {2'b00, opnd_q};
        if (step_div_i) begin
            if (diff_s[WIDTH+1]) begin
                nxt_hi_s = part_s[WIDTH-1:0];
                nxt_lo_s = {acc_lo_q[WIDTH-2:0], 1'b0};
            end else begin
                nxt_hi_s = diff_s[WIDTH-1:0];
                nxt_lo_s = {acc_lo_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            nxt_hi_s = sum_s[WIDTH:1];
            nxt_lo_s = {sum_s[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    // Working registers: loaded on accept, advanced once per iteration.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_hi_q <= {WIDTH{1'b0}};
            acc_lo_q <= {WIDTH{1'b0}};
            opnd_q   <= {WIDTH{1'b0}};
        end else if (load_i) begin
            acc_hi_q <= {WIDTH{1'b0}};
            acc_lo_q <= div_sel_i ? opa_i : opb_i;
            opnd_q   <= div_sel_i ? opb_i : opa_i;
        end else if (step_mult_i || step_div_i) begin
            acc_hi_q <= nxt_hi_s;
            acc_lo_q <= nxt_lo_s;
        end else begin
            acc_hi_q <= acc_hi_q;
            acc_lo_q <= acc_lo_q;
        end
    end

    // Result registers: written on the last iteration or on divide-by-zero.
    // A multiply completion leaves Div_Zero untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_q <= {WIDTH{1'b0}};
            lo_q <= {WIDTH{1'b0}};
            dz_q <= 1'b0;
        end else if (dz_i) begin
            hi_q <= opa_i;
            lo_q <= {WIDTH{1'b1}};
            dz_q <= 1'b1;
        end else if (last_i && (step_mult_i || step_div_i)) begin
            hi_q <= nxt_hi_s;
            lo_q <= nxt_lo_s;
            dz_q <= step_div_i ? 1'b0 : dz_q;
        end else begin
            hi_q <= hi_q;
            lo_q <= lo_q;
            dz_q <= dz_q;
        end
    end

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign div_zero_o = dz_q;

endmodule

// File: rtl/controle_multdiv.sv
// Multi-cycle sequencer for mult/div. Accepts a request in OCIOSO, runs WIDTH
// iterations in MULT or DIV, then pulses Pronto for one cycle in FIM.
// Ocupado and Pronto are registered from the next-state value so they track
// the state register exactly, with no path from inputs to outputs.
module controle_multdiv
    import pacote_multdiv::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] Operando_A,
    input  logic [WIDTH-1:0] Operando_B,
    output logic             Ocupado,
    output logic             Pronto,
    output logic             Div_Zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);

    estado_t         state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ocupado_q, pronto_q;

    logic            load_s;
    logic            div_sel_s;
    logic            step_mult_s;
    logic            step_div_s;
    logic            last_s;
    logic            dz_s;

    // Next-state, iteration counter and datapath enables.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_s      = 1'b0;
        div_sel_s   = 1'b0;
        step_mult_s = 1'b0;
        step_div_s  = 1'b0;
        last_s      = 1'b0;
        dz_s        = 1'b0;
        case (state_q)
            OCIOSO: begin
                if (Start) begin
                    if (Funct == FUNCT_MULT) begin
                        load_s  = 1'b1;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = MULT;
                    end else if (Funct == FUNCT_DIV) begin
                        if (Operando_B != {WIDTH{1'b0}}) begin
                            load_s    = 1'b1;
                            div_sel_s = 1'b1;
                            cnt_d     = CW'(WIDTH - 1);
                            state_d   = DIV;
                        end else begin
                            dz_s    = 1'b1;
                            state_d = FIM;
                        end
                    end else begin
                        state_d = OCIOSO;
                    end
                end else begin
                    state_d = OCIOSO;
                end
            end
            MULT: begin
                step_mult_s = 1'b1;
                if (cnt_q == {CW{1'b0}}) begin
                    last_s  = 1'b1;
                    state_d = FIM;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DIV: begin
                step_div_s = 1'b1;
                if (cnt_q == {CW{1'b0}}) begin
                    last_s  = 1'b1;
                    state_d = FIM;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIM: begin
                state_d = OCIOSO;
            end
            default: begin
                state_d = OCIOSO;
            end
        endcase
    end

    // State, counter and Moore status registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= OCIOSO;
            cnt_q     <= {CW{1'b0}};
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ocupado_q <= (state_d != OCIOSO);
            pronto_q  <= (state_d == FIM);
        end
    end

    multdiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk_i       (Clock),
        .rst_ni      (Reset_n),
        .load_i      (load_s),
        .div_sel_i   (div_sel_s),
        .step_mult_i (step_mult_s),
        .step_div_i  (step_div_s),
        .last_i      (last_s),
        .dz_i        (dz_s),
        .opa_i       (Operando_A),
        .opb_i       (Operando_B),
        .hi_o        (HI),
        .lo_o        (LO),
        .div_zero_o  (Div_Zero)
    );

    assign Ocupado = ocupado_q;
    assign Pronto  = pronto_q;

endmodule
